fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32: number of 32-bit words in the program memory being sequenced.
REQ-002 Parameter DATA_WIDTH, default 32: address, instruction and PC width.
REQ-003 Parameter RESET_PC, default 0: byte address of the first fetch; word-aligned.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level; leaves IDLE and begins fetching.
REQ-007 imem_address  output  DATA_WIDTH  byte address presented to the combinational program memory; equals pc.
REQ-008 imem_instruction  input  DATA_WIDTH  memory read data, valid in the same cycle as imem_address.
REQ-009 redirect_valid  input  1  one-cycle request to change the fetch PC (branch/jump/jr).
REQ-010 redirect_pc  input  DATA_WIDTH  target byte address, sampled when redirect_valid=1.
REQ-011 out_valid  output  1  the out_* bundle holds a fetched instruction.
REQ-012 out_ready  input  1  consumer accepts the bundle when out_valid=1.
REQ-013 out_instruction  output  DATA_WIDTH  fetched instruction word.
REQ-014 out_pc  output  DATA_WIDTH  byte address of out_instruction.
REQ-015 out_pc_plus4  output  DATA_WIDTH  out_pc+4, modulo 2^DATA_WIDTH.
REQ-016 halted  output  1  high while in HALT.
REQ-017 fault  output  1  high while in FAULT (misaligned redirect).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, HALT and FAULT.
- IDLE->RUN: start=1; pc is RESET_PC.
- RUN->HALT: pc leaves range [RESET_PC, RESET_PC+4*MEMORY_DEPTH).
- RUN/HALT->FAULT: redirect_valid=1 with redirect_pc[1:0]!=0.
- HALT->RUN: aligned, in-range redirect.
- FAULT: exits only on reset.
REQ-019 "load" SHALL be true in RUN when pc is in range and (out_valid=0 or out_ready=1).
- On load: out_instruction<=imem_instruction, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
REQ-020 Output latency SHALL be one cycle: an instruction addressed in cycle n appears on out_* after edge n+1. A back-to-back accept SHALL sustain one instruction per cycle.
REQ-021 Stall: when out_valid=1 and out_ready=0, pc and all out_* SHALL hold unchanged.
REQ-022 When out_ready=1 and no load occurs, out_valid SHALL clear at the next edge.
REQ-023 Redirect priority: redirect_valid SHALL override load and stall.
- out_valid<=0 (flush).
- pc<=redirect_pc.
- The stale bundle SHALL NOT be delivered, even if out_ready=1 in the same cycle.
REQ-024 In IDLE, HALT and FAULT, no load SHALL occur. A valid bundle pending on entry to HALT drains normally. FAULT flushes out_valid to 0.
REQ-025 A redirect received in IDLE SHALL update pc and leave the FSM in IDLE.
REQ-026 Address arithmetic SHALL be unsigned DATA_WIDTH modulo 2^DATA_WIDTH. Wrap past the top SHALL be treated as out of range, giving HALT.
REQ-027 Simultaneous start and redirect in IDLE: the FSM SHALL enter RUN with pc=redirect_pc.

Reset
REQ-028 Asynchronous assertion (reset=0) SHALL immediately force:
- state=IDLE, pc=RESET_PC;
- out_valid=0, out_instruction=0, out_pc=0, out_pc_plus4=0;
- halted=0, fault=0.
REQ-029 Reset mid-operation SHALL discard any pending bundle. Release SHALL take effect at the first rising clk edge after reset=1.

Structure
REQ-030 The package fetch_pkg SHALL hold the state typedef (IDLE/RUN/HALT/FAULT) and the constant WORD_BYTES=4.
REQ-031 The output bundle register SHALL be one sub-module, fetch_out_stage: a valid/ready holding register with flush. The FSM and pc SHALL stay in fetch_controller.
REQ-032 The memory interface SHALL connect directly to the existing word-addressed ROM (address>>2) without glue logic.

Verification
REQ-033 Reset, start=1, out_ready=1, ROM word k = 0x1000_0000+k. Required: out_pc 0,4,8,... on consecutive cycles; out_instruction 0x1000_0000, 0x1000_0001, ...; first out_valid one cycle after RUN entry.
REQ-034 Stall: with out_valid=1 and out_pc=8, hold out_ready=0 for 3 cycles. Required: out_pc=8 and imem_address=12 held; on release, next bundle out_pc=12.
REQ-035 Redirect: with out_pc=8 pending and out_ready=1, pulse redirect_valid with redirect_pc=0x40. Required: next cycle out_valid=0; following cycle out_pc=0x40; 0x08 never accepted twice; 0x0C never delivered.
REQ-036 Halt/resume: run off the end, last out_pc=0x7C. Required: halted=1 with no further out_valid. Then redirect_pc=0x10: halted=0 and the next out_pc=0x10.
REQ-037 Fault: redirect_pc=0x22. Required: fault=1 and out_valid=0 next cycle; stays until reset=0.
REQ-038 Assert reset=0 between clock edges mid-stream. Required: out_valid=0 and imem_address=RESET_PC immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_stage.sv
// Valid/ready holding register for the fetched instruction bundle.
// A flush drops the pending bundle without touching its data fields.
module fetch_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             flush,
  input  logic             ready,
  input  logic [WIDTH-1:0] in_instruction,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_pc_plus4,
  output logic             valid,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
);

  // Flush beats load beats drain; data fields change only on a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      instruction <= '0;
      pc          <= '0;
      pc_plus4    <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (load) begin
        instruction <= in_instruction;
        pc          <= in_pc;
        pc_plus4    <= in_pc_plus4;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: walks a program memory window, honours
// redirects, halts when the pc leaves the window and locks on misalignment.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic                  halted,
  output logic                  fault
);

  // One bit wider than the pc so the window end never wraps.
  localparam logic [DATA_WIDTH:0] PC_LIMIT =
    (DATA_WIDTH+1)'(RESET_PC) + (DATA_WIDTH+1)'(WORD_BYTES * MEMORY_DEPTH);

  fetch_state_t state, state_next;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH:0]   pc_incr;
  logic                  pc_wrap;
  logic                  pc_in_range;
  logic                  redirect_aligned;
  logic                  redirect_in_range;
  logic                  load;
  logic                  flush;

  assign pc_incr           = {1'b0, pc} + (DATA_WIDTH+1)'(WORD_BYTES);
  assign pc_plus4          = pc_incr[DATA_WIDTH-1:0];
  assign pc_wrap           = pc_incr[DATA_WIDTH];
  assign pc_in_range       = (pc >= RESET_PC) && ({1'b0, pc} < PC_LIMIT);
  assign redirect_aligned  = (redirect_pc[1:0] == 2'b00);
  assign redirect_in_range = (redirect_pc >= RESET_PC) && ({1'b0, redirect_pc} < PC_LIMIT);
  assign imem_address      = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (redirect_valid && !redirect_aligned) state_next = FAULT;
        else if (redirect_valid)                 state_next = RUN;
        else if (!pc_in_range || (load && pc_wrap)) state_next = HALT;
      end
      HALT: begin
        if (redirect_valid && !redirect_aligned)       state_next = FAULT;
        else if (redirect_valid && redirect_in_range)  state_next = RUN;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    halted = (state == HALT);
    fault  = (state == FAULT);
    load   = (state == RUN) && pc_in_range && (!out_valid || out_ready) && !redirect_valid;
    flush  = redirect_valid || (state == FAULT);
  end

  // A frozen FAULT ignores redirects; everywhere else a redirect wins over a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid && (state != FAULT)) begin
      pc <= redirect_pc;
    end else if (load) begin
      pc <= pc_plus4;
    end
  end

  fetch_out_stage #(
    .WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .flush         (flush),
    .ready         (out_ready),
    .in_instruction(imem_instruction),
    .in_pc         (pc),
    .in_pc_plus4   (pc_plus4),
    .valid         (out_valid),
    .instruction   (out_instruction),
    .pc            (out_pc),
    .pc_plus4      (out_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized bench for fetch_controller against a cycle-level
// behavioural model of the fetch rules, with a combinational ROM.
module tb_fetch_controller;

  localparam int          DEPTH = 32;
  localparam logic [31:0] RPC   = 32'h0;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_address, imem_instruction;
  logic [31:0] out_instruction, out_pc, out_pc_plus4;
  logic        out_valid, halted, fault;

  int vectors = 0;
  int miscompares = 0;

  int          m_mode;
  logic [31:0] m_pc, m_instr, m_opc, m_p4;
  bit          m_valid;

  int          acc08 = 0;
  int          acc0c = 0;
  logic [31:0] last_acc = 32'h0;

  always #5 clk = ~clk;

  fetch_controller #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (32),
    .RESET_PC    (RPC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .halted          (halted),
    .fault           (fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if ((a >> 2) < DEPTH) return 32'h1000_0000 + (a >> 2);
    return 32'hdead_beef;
  endfunction

  assign imem_instruction = rom_word(imem_address);

  function automatic bit in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(RPC)) && (longint'(a) < longint'(RPC) + 4 * DEPTH);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    checkVal({tag, ".out_pc"}, out_pc, m_opc);
    checkVal({tag, ".out_instruction"}, out_instruction, m_instr);
    checkVal({tag, ".out_pc_plus4"}, out_pc_plus4, m_p4);
    checkVal({tag, ".imem_address"}, imem_address, m_pc);
    checkVal({tag, ".halted"}, 32'(halted), 32'(m_mode == M_HALT));
    checkVal({tag, ".fault"}, 32'(fault), 32'(m_mode == M_FAULT));
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = RPC;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_opc   = 32'h0;
    m_p4    = 32'h0;
  endtask

  // Drives one cycle of inputs, advances the model by the fetch rules and
  // returns 1 time unit after the rising edge.
  task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          inr, ld, mis, nv;
    int          nm;
    logic [32:0] inc;
    logic [31:0] npc, ni, no, np4;
    start          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    if (out_valid && rdy && !rv) begin
      if (out_pc == 32'h08) acc08++;
      if (out_pc == 32'h0c) acc0c++;
      last_acc = out_pc;
    end
    inr = in_range(m_pc);
    ld  = (m_mode == M_RUN) && inr && (!m_valid || rdy) && !rv;
    mis = (rpc[1:0] != 2'b00);
    inc = {1'b0, m_pc} + 33'd4;
    nm  = m_mode;
    case (m_mode)
      M_IDLE: if (st) nm = M_RUN;
      M_RUN: begin
        if (rv && mis) nm = M_FAULT;
        else if (rv) nm = M_RUN;
        else if (!inr || (ld && inc[32])) nm = M_HALT;
      end
      M_HALT: begin
        if (rv && mis) nm = M_FAULT;
        else if (rv && in_range(rpc)) nm = M_RUN;
      end
      default: nm = m_mode;
    endcase
    if (rv && m_mode != M_FAULT) npc = rpc;
    else if (ld) npc = inc[31:0];
    else npc = m_pc;
    if (rv || m_mode == M_FAULT) nv = 1'b0;
    else if (ld) nv = 1'b1;
    else if (rdy) nv = 1'b0;
    else nv = m_valid;
    ni  = ld ? rom_word(m_pc) : m_instr;
    no  = ld ? m_pc : m_opc;
    np4 = ld ? inc[31:0] : m_p4;
    @(posedge clk);
    #1;
    m_mode  = nm;
    m_pc    = npc;
    m_valid = nv;
    m_instr = ni;
    m_opc   = no;
    m_p4    = np4;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    checkOutput(tag);
    checkVal({tag, ".immediate_valid"}, 32'(out_valid), 32'h0);
    checkVal({tag, ".immediate_addr"}, imem_address, RPC);
    #2 reset = 1'b1;
  endtask

  initial begin
    int cyc;
    model_reset();
    #2;
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("run_entry");
    checkVal("run_entry.no_valid_yet", 32'(out_valid), 32'h0);
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("seq0");
    checkVal("seq0.pc", out_pc, 32'h0);
    checkVal("seq0.instr", out_instruction, 32'h1000_0000);
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("seq1");
    checkVal("seq1.instr", out_instruction, 32'h1000_0001);
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("seq2");
    checkVal("seq2.pc", out_pc, 32'h8);

    repeat (3) begin
      applyStimulus(1, 0, 32'h0, 0);
      checkOutput("stall");
      checkVal("stall.pc", out_pc, 32'h8);
      checkVal("stall.addr", imem_address, 32'hc);
    end
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("stall_release");
    checkVal("stall_release.pc", out_pc, 32'hc);

    applyStimulus(1, 1, 32'h8, 1);
    checkOutput("redir8");
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("redir8_load");
    checkVal("redir8_load.pc", out_pc, 32'h8);
    applyStimulus(1, 1, 32'h40, 1);
    checkOutput("redir40");
    checkVal("redir40.flush", 32'(out_valid), 32'h0);
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("redir40_load");
    checkVal("redir40_load.pc", out_pc, 32'h40);
    checkVal("accept_08_count", 32'(acc08), 32'h1);
    checkVal("accept_0c_count", 32'(acc0c), 32'h0);

    cyc = 0;
    while (!halted && cyc < 60) begin
      applyStimulus(1, 0, 32'h0, 1);
      checkOutput("to_halt");
      cyc++;
    end
    checkVal("halt.reached", 32'(halted), 32'h1);
    checkVal("halt.last_pc", last_acc, 32'h7c);
    repeat (3) begin
      applyStimulus(0, 0, 32'h0, 1);
      checkOutput("halt_idle");
      checkVal("halt_idle.valid", 32'(out_valid), 32'h0);
    end
    applyStimulus(0, 1, 32'h10, 1);
    checkOutput("resume");
    checkVal("resume.halted", 32'(halted), 32'h0);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("resume_load");
    checkVal("resume_load.pc", out_pc, 32'h10);

    applyStimulus(0, 1, 32'h22, 1);
    checkOutput("fault");
    checkVal("fault.flag", 32'(fault), 32'h1);
    checkVal("fault.valid", 32'(out_valid), 32'h0);
    repeat (3) begin
      applyStimulus(1, 1, 32'h40, 1);
      checkOutput("fault_hold");
      checkVal("fault_hold.flag", 32'(fault), 32'h1);
    end
    async_reset("fault_clear");

    applyStimulus(0, 1, 32'h30, 0);
    checkOutput("idle_redirect");
    checkVal("idle_redirect.addr", imem_address, 32'h30);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("idle_hold");
    applyStimulus(1, 1, 32'h20, 1);
    checkOutput("start_redirect");
    checkVal("start_redirect.addr", imem_address, 32'h20);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("start_redirect_load");
    checkVal("start_redirect_load.pc", out_pc, 32'h20);
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("midstream");
    async_reset("async_reset");

    repeat (1500) begin
      bit          st, rv, rdy;
      logic [31:0] rpc;
      int          sel;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      if (sel == 0)      rpc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) rpc = 32'h80 + (32'($urandom_range(0, 31)) << 2);
      else if (sel == 2) rpc = 32'hffff_fffc;
      else               rpc = 32'($urandom_range(0, DEPTH - 1)) << 2;
      applyStimulus(st, rv, rpc, rdy);
      checkOutput("random");
      if ($urandom_range(0, 99) == 0) async_reset("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
